// File: rtl/ps2kb_pkg.sv
// Shared types and constants for the PS/2 keyboard responder.
// Optional build macro used by this slice: PS2KB_WATCHDOG_EN (mid-frame timeout).
package ps2kb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_e;

  localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
  localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;
  localparam logic [7:0] PS2_ERR_00     = 8'h00;
  localparam logic [7:0] PS2_ERR_FF     = 8'hFF;

  localparam int KEY_W   = 10;
  localparam int BRK_BIT = 9;
  localparam int EXT_BIT = 8;

  // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2kb_responder_if.sv
// Bus-side signals between the MIO decoder (master) and the keyboard responder (slave).
interface ps2kb_responder_if;
  import ps2kb_pkg::*;

  logic             ps2kb_rd;
  logic [KEY_W-1:0] ps2kb_key;
  logic             key_ready;
  logic             overflow;
  logic             frame_err;

  modport master (
    output ps2kb_rd,
    input  ps2kb_key,
    input  key_ready,
    input  overflow,
    input  frame_err
  );

  modport slave (
    input  ps2kb_rd,
    output ps2kb_key,
    output key_ready,
    output overflow,
    output frame_err
  );

endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: pin synchroniser, falling-edge detect,
// 11-bit frame FSM and, with PS2KB_WATCHDOG_EN defined, a mid-frame timeout.
module ps2_frame_rx
  import ps2kb_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_o,
  output logic       frame_err_o,
  output logic       abort_o
);

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   sync_clk_q;
  logic                   sync_clk_s;
  logic                   sync_data_s;
  logic                   fall_s;
  logic                   wd_expire_s;

  rx_state_e  state_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] shift_q;
  logic       parity_q;
  logic       byte_valid_q;
  logic [7:0] byte_q;
  logic       frame_err_q;
  logic       abort_q;

  assign sync_clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign sync_data_s = data_sync_q[SYNC_STAGES-1];
  assign fall_s      = sync_clk_q & ~sync_clk_s;

  // Synchronise both asynchronous pins; idle level of the PS/2 lines is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q  <= {SYNC_STAGES{1'b1}};
      data_sync_q <= {SYNC_STAGES{1'b1}};
      sync_clk_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
      sync_clk_q  <= sync_clk_s;
    end
  end

`ifdef PS2KB_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_cnt_q;

  // Count idle cycles inside a frame; any falling edge restarts the count.
  always_ff @(posedge clk) begin
    if (rst || (state_q == ST_IDLE) || fall_s) begin
      wd_cnt_q <= {WD_W{1'b0}};
    end else begin
      wd_cnt_q <= wd_cnt_q + WD_W'(1);
    end
  end

  assign wd_expire_s = (state_q != ST_IDLE) && !fall_s && (wd_cnt_q == WD_LAST);
`else
  logic wd_unused_s;
  assign wd_unused_s = (TIMEOUT_CYCLES != 0);
  assign wd_expire_s = 1'b0;
`endif

  // Frame FSM: start, 8 data bits LSB first, odd parity, stop; outputs are registered pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      parity_q     <= 1'b0;
      byte_valid_q <= 1'b0;
      byte_q       <= 8'h00;
      frame_err_q  <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      abort_q      <= 1'b0;
      if (wd_expire_s) begin
        state_q     <= ST_IDLE;
        frame_err_q <= 1'b1;
        abort_q     <= 1'b1;
      end else if (fall_s) begin
        case (state_q)
          ST_IDLE: begin
            if (!sync_data_s) begin
              state_q   <= ST_DATA;
              bit_cnt_q <= 3'd0;
            end else begin
              state_q <= ST_IDLE;
            end
          end
          ST_DATA: begin
            shift_q <= {sync_data_s, shift_q[7:1]};
            if (bit_cnt_q == 3'd7) begin
              state_q <= ST_PARITY;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
          ST_PARITY: begin
            parity_q <= sync_data_s;
            state_q  <= ST_STOP;
          end
          ST_STOP: begin
            state_q <= ST_IDLE;
            if (sync_data_s && odd_parity_ok(shift_q, parity_q)) begin
              byte_valid_q <= 1'b1;
              byte_q       <= shift_q;
            end else begin
              frame_err_q <= 1'b1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end else begin
        state_q <= state_q;
      end
    end
  end

  assign byte_valid_o = byte_valid_q;
  assign byte_o       = byte_q;
  assign frame_err_o  = frame_err_q;
  assign abort_o      = abort_q;

endmodule

// File: rtl/ps2kb_responder.sv
// PS/2 keyboard responder: frame receiver, E0/F0 prefix folding into 10-bit key
// words, key FIFO with registered head and edge-triggered pop from the bus.
// Build macro PS2KB_WATCHDOG_EN enables the mid-frame timeout in ps2_frame_rx.
module ps2kb_responder
  import ps2kb_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ps2_clk,
  input  logic               ps2_data,
  ps2kb_responder_if.slave   bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic             rx_valid_s;
  logic [7:0]       rx_byte_s;
  logic             rx_err_s;
  logic             rx_abort_s;

  logic [KEY_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             ext_q;
  logic             ext_d;
  logic             brk_q;
  logic             brk_d;
  logic             rd_q;
  logic [KEY_W-1:0] key_q;
  logic             key_ready_q;
  logic             overflow_q;

  logic             push_s;
  logic [KEY_W-1:0] push_word_s;
  logic             pop_s;
  logic             full_s;
  logic             wr_en_s;

  ps2_frame_rx #(
    .SYNC_STAGES    (SYNC_STAGES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk          (clk),
    .rst          (rst),
    .ps2_clk_i    (ps2_clk),
    .ps2_data_i   (ps2_data),
    .byte_valid_o (rx_valid_s),
    .byte_o       (rx_byte_s),
    .frame_err_o  (rx_err_s),
    .abort_o      (rx_abort_s)
  );

  // Prefix decoder: fold E0/F0 into flags, drop keyboard error codes, push everything else.
  always_comb begin
    push_s                = 1'b0;
    push_word_s           = {2'b00, rx_byte_s};
    push_word_s[BRK_BIT]  = brk_q;
    push_word_s[EXT_BIT]  = ext_q;
    ext_d                 = ext_q;
    brk_d                 = brk_q;
    if (rx_abort_s) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (rx_valid_s) begin
      case (rx_byte_s)
        PS2_EXT_PREFIX: ext_d = 1'b1;
        PS2_BRK_PREFIX: brk_d = 1'b1;
        PS2_ERR_00, PS2_ERR_FF: begin
          ext_d = 1'b0;
          brk_d = 1'b0;
        end
        default: begin
          push_s = 1'b1;
          ext_d  = 1'b0;
          brk_d  = 1'b0;
        end
      endcase
    end else begin
      push_s = 1'b0;
    end
  end

  // Pop only on the rising edge of the read select and only when something is queued;
  // when full, a concurrent pop frees the slot the push needs.
  always_comb begin
    full_s  = (count_q == DEPTH_C);
    pop_s   = bus.ps2kb_rd & ~rd_q & (count_q != {CW{1'b0}});
    wr_en_s = push_s & (~full_s | pop_s);
    case ({wr_en_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage write port; contents are only observed through count-qualified reads.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= push_word_s;
    end
  end

  // FIFO pointers, prefix flags, sticky overflow and registered bus outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      count_q     <= {CW{1'b0}};
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      rd_q        <= 1'b0;
      key_q       <= {KEY_W{1'b0}};
      key_ready_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      rd_q    <= bus.ps2kb_rd;
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      count_q <= count_d;
      if (wr_en_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (pop_s) begin
        overflow_q <= 1'b0;
      end else if (push_s && full_s) begin
        overflow_q <= 1'b1;
      end
      key_q       <= (count_q != {CW{1'b0}}) ? mem_q[rd_ptr_q] : {KEY_W{1'b0}};
      key_ready_q <= (count_q != {CW{1'b0}});
    end
  end

  assign bus.ps2kb_key = key_q;
  assign bus.key_ready = key_ready_q;
  assign bus.overflow  = overflow_q;
  assign bus.frame_err = rx_err_s;

endmodule

// File: tb/tb_ps2kb_responder.sv
// Directed self-checking bench for ps2kb_responder (FIFO_DEPTH 8, SYNC_STAGES 2).
// The watchdog step only runs when PS2KB_WATCHDOG_EN is defined.
module tb_ps2kb_responder;

  logic clk = 1'b0;
  logic rst;
  logic ps2_clk;
  logic ps2_data;
  int   total = 0;
  int   bad   = 0;
  int   fe_cnt = 0;
  int   fe0;
  int   lat;

  ps2kb_responder_if bus ();

  ps2kb_responder #(
    .FIFO_DEPTH     (8),
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Count frame_err high cycles so pulse width can be checked.
  always @(negedge clk) begin
    if (bus.frame_err === 1'b1) fe_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic ps2_bit(input logic v);
    @(negedge clk) ps2_data = v;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (8) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic flip_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ flip_par);
    ps2_bit(1'b1);
    repeat (8) @(negedge clk);
  endtask

  task automatic pop1;
    @(negedge clk) bus.ps2kb_rd = 1'b1;
    repeat (4) @(negedge clk);
    bus.ps2kb_rd = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    bus.ps2kb_rd = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_key", 32'(bus.ps2kb_key), 32'h000);
    chk("rst_ready", 32'(bus.key_ready), 32'h0);
    chk("rst_ovf", 32'(bus.overflow), 32'h0);
    chk("rst_ferr", 32'(bus.frame_err), 32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 0x1C frame with latency measured from the stop-bit falling edge
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(((8'h1C >> i) & 8'h01) != 8'h00);
    ps2_bit(1'b0);
    @(negedge clk) ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b0;
    lat = 99;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (bus.key_ready === 1'b1 && lat == 99) lat = k;
    end
    chk("latency_le_5", 32'(lat <= 5), 32'h1);
    chk("key_1c", 32'(bus.ps2kb_key), 32'h01C);
    ps2_clk = 1'b1;
    repeat (8) @(negedge clk);
    pop1();
    chk("pop_key0", 32'(bus.ps2kb_key), 32'h000);
    chk("pop_ready0", 32'(bus.key_ready), 32'h0);

    // Prefix folding
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b0);
    chk("brk_1c", 32'(bus.ps2kb_key), 32'h21C);
    pop1();
    chk("brk_single", 32'(bus.key_ready), 32'h0);
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h75, 1'b0);
    chk("extbrk_75", 32'(bus.ps2kb_key), 32'h375);
    pop1();
    chk("extbrk_single", 32'(bus.key_ready), 32'h0);
    send_byte(8'hE0, 1'b0);
    send_byte(8'h75, 1'b0);
    chk("ext_75", 32'(bus.ps2kb_key), 32'h175);
    pop1();
    chk("ext_single", 32'(bus.key_ready), 32'h0);

    // Bad parity then a good byte; keyboard error code is dropped
    fe0 = fe_cnt;
    send_byte(8'h1C, 1'b1);
    chk("par_err_pulse", 32'(fe_cnt - fe0), 32'd1);
    chk("par_err_nopush", 32'(bus.key_ready), 32'h0);
    send_byte(8'h00, 1'b0);
    chk("err00_dropped", 32'(bus.key_ready), 32'h0);
    send_byte(8'h32, 1'b0);
    chk("key_32", 32'(bus.ps2kb_key), 32'h032);
    pop1();

    // Pop while empty must not disturb the count
    pop1();
    send_byte(8'h2B, 1'b0);
    chk("after_empty_pop", 32'(bus.ps2kb_key), 32'h02B);
    pop1();
    chk("after_empty_pop_ready", 32'(bus.key_ready), 32'h0);

    // Overflow: nine keys into an eight-deep FIFO
    for (int i = 0; i < 9; i++) send_byte(8'h15 + 8'(i), 1'b0);
    chk("ovf_set", 32'(bus.overflow), 32'h1);
    chk("ovf_head", 32'(bus.ps2kb_key), 32'h015);
    for (int i = 0; i < 8; i++) begin
      chk("ovf_order", 32'(bus.ps2kb_key), 32'h015 + 32'(i));
      pop1();
      if (i == 0) chk("ovf_clear", 32'(bus.overflow), 32'h0);
    end
    chk("ovf_drained", 32'(bus.key_ready), 32'h0);

    // Reset in the middle of a frame with a key already queued
    send_byte(8'h4D, 1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_key", 32'(bus.ps2kb_key), 32'h000);
    chk("midrst_ready", 32'(bus.key_ready), 32'h0);
    chk("midrst_ovf", 32'(bus.overflow), 32'h0);
    send_byte(8'h1C, 1'b0);
    chk("midrst_1c", 32'(bus.ps2kb_key), 32'h01C);
    pop1();

`ifdef PS2KB_WATCHDOG_EN
    // Start bit only, then the PS/2 clock stays idle
    fe0 = fe_cnt;
    @(negedge clk) ps2_data = 1'b0;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (8) @(negedge clk);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    lat = 0;
    for (int k = 9; k <= 400; k++) begin
      @(negedge clk);
      if (fe_cnt != fe0 && lat == 0) lat = k;
    end
    chk("wd_fired", 32'(fe_cnt - fe0), 32'd1);
    chk("wd_timing", 32'(lat >= 95 && lat <= 115), 32'h1);
    chk("wd_nopush", 32'(bus.key_ready), 32'h0);
    send_byte(8'h29, 1'b0);
    chk("wd_next_29", 32'(bus.ps2kb_key), 32'h029);
    pop1();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2kb_responder.md
Name: ps2kb_responder

Overview:
- Keyboard-side responder behind the MIO bus decoder's 0xD region.
- Samples the PS/2 clock/data pins, deframes 11-bit device-to-host frames, and folds E0/F0 prefixes into 10-bit key words.
- Buffers key words in a small FIFO and presents the head on the bus read-data path.
- Pops one entry per bus read strobe from the decoder.

Parameters:
- FIFO_DEPTH, 8, key-word FIFO entries; power of 2, min 2.
- SYNC_STAGES, 2, flip-flop synchroniser depth on ps2_clk and ps2_data.
- TIMEOUT_CYCLES, 50000, idle clk cycles mid-frame before abort (watchdog feature only).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous
- ps2_data  in  1  raw PS/2 data pin, asynchronous
- ps2kb_rd  in  1  read-select level from bus decoder (may stay high several cycles)
- ps2kb_key  out  10  FIFO head {brk, ext, code[7:0]}; 10'h000 when empty
- key_ready  out  1  FIFO non-empty
- overflow  out  1  sticky: a key word was dropped because the FIFO was full
- frame_err  out  1  one-cycle pulse on parity, start or stop error (or timeout)

Behaviour:
- Reset values:
  - ps2kb_key = 0, key_ready = 0, overflow = 0, frame_err = 0.
  - FIFO emptied; prefix flags cleared; FSM in IDLE.
  - Synchroniser stages and edge-detect register set to 1 (PS/2 lines idle high).
- Reset mid-frame discards the partial frame. No key word is pushed.
- Edge detect: a falling edge is sync_clk_q = 1 and sync_clk = 0. All frame sampling uses sync_data at that cycle.
- Frame FSM:
  - IDLE: on edge, data = 0 -> DATA with bit counter = 0; data = 1 -> stay IDLE (spurious).
  - DATA: on edge, shift data in LSB-first; after the 8th bit -> PARITY.
  - PARITY: on edge, capture the bit -> STOP.
  - STOP: on edge -> IDLE. The byte is accepted only if stop = 1 and XOR(data[7:0], parity) = 1 (odd parity).
  - On failure, pulse frame_err and drop the byte.
- Prefix decoder, on an accepted byte, the cycle after the STOP edge:
  - 8'hE0: ext flag = 1, no push.
  - 8'hF0: brk flag = 1, no push.
  - 8'h00 or 8'hFF (keyboard error/overrun codes): dropped, flags cleared.
  - Any other byte: push {brk, ext, byte}, then clear both flags.
- Latency: key word visible on ps2kb_key no later than SYNC_STAGES+3 clk after the stop-bit falling edge on the pin.
- Pop handling:
  - pop = ps2kb_rd & ~ps2kb_rd_q, i.e. rising edge only, so one bus access pops exactly one entry.
  - ps2kb_key is the registered head. After a pop it updates on the next cycle.
  - Pop when empty: ignored.
- Push when full, no pop: word dropped, overflow set.
- Simultaneous push and pop:
  - When full: both take effect, count unchanged, overflow not set.
  - When empty: only the push takes effect.
- overflow clears on the next successful pop, or on rst.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits.

Optional Feature:
- Macro: PS2KB_WATCHDOG_EN.
- Defined:
  - A counter runs while the FSM is not IDLE and resets on every falling edge.
  - On reaching TIMEOUT_CYCLES: FSM -> IDLE, frame_err pulses, prefix flags clear.
- Undefined:
  - No counter; the FSM waits indefinitely for edges.
  - TIMEOUT_CYCLES is unused.

Decomposition:
- Package ps2kb_pkg:
  - FSM state encoding (IDLE/DATA/PARITY/STOP).
  - Constants PS2_EXT_PREFIX = 8'hE0, PS2_BRK_PREFIX = 8'hF0, PS2_ERR_00, PS2_ERR_FF.
  - Key-word field indices BRK_BIT = 9, EXT_BIT = 8.
- Sub-module ps2_frame_rx: synchroniser, edge detect, frame FSM and watchdog; outputs byte_valid/byte/frame_err.
- The top level holds the prefix decoder, FIFO and pop logic.

Test Plan:
- Frame 0x1C with parity 0, stop 1 -> ps2kb_key = 10'h01C, key_ready = 1 within SYNC_STAGES+3 clk. A ps2kb_rd held high 4 cycles -> one pop, key = 0, key_ready = 0.
- Bytes F0, 1C -> single entry 10'h21C. Bytes E0, F0, 75 -> single entry 10'h375. Bytes E0, 75 -> 10'h175.
- Byte 0x1C sent with parity bit 1 -> frame_err one-cycle pulse, FIFO unchanged. A following good 0x32 -> 10'h032.
- Push 9 keys 0x15..0x1D with no reads (FIFO_DEPTH = 8) -> overflow = 1 and head = 10'h015. Eight pops return 0x15..0x1C in order. overflow clears after the first pop.
- rst asserted after 4 data bits of a frame -> all outputs 0. A subsequent full 0x1C frame decodes correctly as 10'h01C.
- PS2KB_WATCHDOG_EN defined, TIMEOUT_CYCLES = 100: start bit then clock stops -> frame_err at cycle 100 after the last edge, FSM in IDLE. The next frame 0x29 -> 10'h029.
